receiver_buffer: RTL

//  Receive-side data buffer of the CoreUART: the counterpart of the transmit buffer.

---
 rtl/receiver_buffer_pkg.sv | 7 +
 rtl/receiver_buffer.sv | 77 +++++++
 2 files changed

// File: rtl/receiver_buffer_pkg.sv
// receiver_buffer_pkg: shared UART receive-side widths and entry layout
package receiver_buffer_pkg;
  localparam int BITWIDTH = 8;
  localparam int EW = BITWIDTH + 2;
  localparam int PERR_BIT = BITWIDTH;
  localparam int FERR_BIT = BITWIDTH + 1;
endpackage

// File: rtl/receiver_buffer.sv
// receiver_buffer: circular FIFO between the receiver core and the CPU read port
module receiver_buffer
  import receiver_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic                rClk,
  input  logic                rRst,
  input  logic                rWR,
  input  logic [BITWIDTH-1:0] rdataIn,
  input  logic                rPERR,
  input  logic                rFERR,
  input  logic                rRD,
  input  logic                rClrOvf,
  output logic [BITWIDTH-1:0] rdataOut,
  output logic                rPERRout,
  output logic                rFERRout,
  output logic                rVALID,
  output logic                rEMPTY,
  output logic                rFULL,
  output logic                rxrdy,
  output logic                rOVF,
  output logic [AW:0]         rCOUNT
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] out_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic valid_q, ovf_q, ovf_d;
  logic empty, full, do_rd, do_wr, drop;
  assign empty = count_q == '0;
  assign full = count_q == FULL_CNT;
  assign rEMPTY = empty;
  assign rFULL = full;
  assign rxrdy = !empty;
  assign rCOUNT = count_q;
  assign rdataOut = out_q[BITWIDTH-1:0];
  assign rPERRout = out_q[PERR_BIT];
  assign rFERRout = out_q[FERR_BIT];
  assign rVALID = valid_q;
  assign rOVF = ovf_q;
  // Accept/drop decisions; a read on a full FIFO frees the slot the write needs
  always_comb begin
    do_rd = rRD && !empty;
    do_wr = rWR && (!full || do_rd);
    drop = rWR && full && !do_rd;
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = (do_wr && !do_rd) ? count_q + (AW+1)'(1) :
              (do_rd && !do_wr) ? count_q - (AW+1)'(1) : count_q;
    ovf_d = drop ? 1'b1 : rClrOvf ? 1'b0 : ovf_q;
  end
  // Storage array is never reset; stale contents are unreachable once count is 0
  always_ff @(posedge rClk) begin
    if (do_wr) mem_q[wr_ptr_q] <= {rFERR, rPERR, rdataIn};
  end
  // Pointers, occupancy, registered read port and sticky overflow
  always_ff @(posedge rClk or negedge rRst) begin
    if (!rRst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      valid_q <= do_rd;
      ovf_q <= ovf_d;
      if (do_rd) out_q <= mem_q[rd_ptr_q];
    end
  end
endmodule
